sobel_stream_ctrl: RTL and testbench
====================================

# sobel_stream_ctrl

Sequencer for the Sobel 3x3 window buffer. It accepts a raster-order grayscale pixel stream through a valid/ready handshake and drives the buffer's pixel and enable inputs. It tracks row and column position per frame and flags exactly those cycles where the buffer's nine window outputs hold a complete in-image 3x3 neighbourhood. It sits between the pixel source and the window buffer / gradient stage, and brackets each frame with start/busy/done.

## Interface
- IMG_WIDTH, 6, pixels per row (>= 3)
- IMG_HEIGHT, 5, rows per frame (>= 3)
- Port widths: CW = $clog2(IMG_WIDTH), RW = $clog2(IMG_HEIGHT)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  begin a frame; sampled only in IDLE
- pix_valid_i  in  1  upstream pixel valid
- pix_data_i  in  8  upstream grayscale pixel
- pix_ready_o  out  1  controller can accept a pixel
- buf_en_o  out  1  to buffer enable input; = pix_valid_i & pix_ready_o (combinational)
- buf_data_o  out  8  to buffer pixel input; = pix_data_i (combinational)
- win_valid_o  out  1  buffer window outputs are a valid full window this cycle
- win_row_o  out  RW  centre row of the flagged window
- win_col_o  out  CW  centre column of the flagged window
- busy_o  out  1  high in FILL and RUN
- frame_done_o  out  1  one-cycle pulse at end of frame

## Operation
- Accept: pixel accepted on a rising edge when pix_valid_i & pix_ready_o.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) hold the position of the next pixel.
  - On accept: col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - Both clear on entry to FILL.
- States:
  - IDLE: pix_ready_o = 0. start_i = 1 -> FILL.
  - FILL (rows 0-1): pix_ready_o = 1. Accepting pixel (1, IMG_WIDTH-1) -> RUN.
  - RUN (rows 2..IMG_HEIGHT-1): pix_ready_o = 1. Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) -> DONE.
  - DONE: pix_ready_o = 0, frame_done_o = 1. Unconditional -> IDLE.
- Window flag: accepting pixel (r, c) with r >= 2 and c >= 2 produces one window.
  - The flag is registered: win_valid_o = 1 in the next cycle.
  - win_row_o = r-1 and win_col_o = c-1 in that same cycle.
- Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2); columns 0-1 of each row never produce a window.
- start_i outside IDLE is ignored. pix_valid_i in IDLE or DONE is not accepted and has no effect.
- No arithmetic beyond the counters; counter widths are CW/RW, and win_row_o/win_col_o never exceed IMG_HEIGHT-2 / IMG_WIDTH-2.

## Timing
- Reset values: state IDLE, row = col = 0; pix_ready_o, win_valid_o, busy_o, frame_done_o = 0; win_row_o = win_col_o = 0.
  - buf_en_o = 0 follows from pix_ready_o = 0.
- start_i high at edge N -> FILL from cycle N+1; pix_ready_o = 1 in cycle N+1.
- Window latency: one cycle from accept edge to win_valid_o. This matches the buffer, which updates its window outputs on the same edge that enables it.
- Back-to-back accepts give back-to-back win_valid_o pulses. Gaps in pix_valid_i give gaps in win_valid_o; counters hold.
- Last-pixel accept at edge M:
  - cycle M+1: DONE, frame_done_o = 1, and the final win_valid_o = 1 (simultaneous).
  - cycle M+2: IDLE.
- Earliest next start: start_i is sampled at edge M+2 (first IDLE edge).
- rst mid-frame: all state returns to reset values at the next edge, and any pending win_valid_o is dropped. The window buffer must share the same rst.

## Configuration
- SOBEL_CTRL_BACKPRESSURE_EN defined:
  - adds input win_ready_i (1 bit) from the downstream gradient stage.
  - In FILL/RUN, pix_ready_o = win_ready_i.
  - A stalled downstream therefore stops acceptance and freezes counters, buffer and win_valid_o generation.
  - win_valid_o, once high, holds with unchanged win_row_o/win_col_o until a cycle with win_ready_i = 1.
- Undefined: no win_ready_i port; pix_ready_o = 1 throughout FILL/RUN.

## Test plan
- Reset then idle: rst for 2 cycles, pix_valid_i = 1 with no start -> pix_ready_o, buf_en_o, win_valid_o, busy_o all 0.
- Full 6x5 frame, continuous: start, then pixels 1..30 on consecutive cycles ->
  - first win_valid_o the cycle after pixel 15, centre (1,1), buffer window 1,2,3,7,8,9,13,14,15;
  - last win_valid_o centre (3,4) after pixel 30;
  - 12 windows total;
  - frame_done_o coincides with the last window.
- Gapped stream: pix_valid_i low every other cycle -> same 12 windows and centres, with gaps; counters hold during gaps.
- Extra pixels: pixels 31..36 presented after pixel 30 -> none accepted (pix_ready_o = 0 in DONE/IDLE), no extra windows.
- Reset mid-frame: rst after pixel 17 -> IDLE next cycle, outputs 0. New start plus 30 pixels -> exactly 12 windows starting from centre (1,1).
- Backpressure (macro on): win_ready_i low for 3 cycles when centre (1,2) is flagged -> win_valid_o and centre held 3 cycles, pix_ready_o = 0 meanwhile, no pixel lost, 12 windows total.

Source files
------------

// File: rtl/sobel_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_stream_ctrl
//  Description : Sequencer for the Sobel 3x3 window buffer. Accepts a raster
//                pixel stream over valid/ready, drives the buffer enable and
//                pixel inputs, tracks row/column per frame and flags the
//                cycles where the buffer holds a complete in-image window.
//                Optional downstream backpressure is enabled by defining
//                SOBEL_CTRL_BACKPRESSURE_EN (adds win_ready_i).
//  Revision    : 1.0 - initial release
// ============================================================================
module sobel_stream_ctrl #(
    parameter  int IMG_WIDTH  = 6,
    parameter  int IMG_HEIGHT = 5,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SOBEL_CTRL_BACKPRESSURE_EN
    input  logic          win_ready_i,
`endif
    input  logic          start_i,
    input  logic          pix_valid_i,
    input  logic [7:0]    pix_data_i,
    output logic          pix_ready_o,
    output logic          buf_en_o,
    output logic [7:0]    buf_data_o,
    output logic          win_valid_o,
    output logic [RW-1:0] win_row_o,
    output logic [CW-1:0] win_col_o,
    output logic          busy_o,
    output logic          frame_done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] c_ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] c_COL_ONE       = CW'(1);
    localparam logic [RW-1:0] c_ROW_ONE       = RW'(1);
    localparam logic [CW-1:0] c_COL_FIRST_WIN = CW'(2);
    localparam logic [RW-1:0] c_ROW_FIRST_WIN = RW'(2);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_win_valid;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic          w_active;
    logic          w_down_ready;
    logic          w_accept;
    logic          w_col_last;
    logic          w_win_fire;

`ifdef SOBEL_CTRL_BACKPRESSURE_EN
    assign w_down_ready = win_ready_i;
`else
    assign w_down_ready = 1'b1;
`endif

    assign w_accept   = pix_valid_i & pix_ready_o;
    assign w_col_last = (r_col == c_COL_LAST);
    // The buffer's window is complete once the incoming pixel is at least two
    // rows and two columns into the image; its centre is one up and one left.
    assign w_win_fire = w_accept && (r_row >= c_ROW_FIRST_WIN) && (r_col >= c_COL_FIRST_WIN);

    assign buf_en_o    = w_accept;
    assign buf_data_o  = pix_data_i;
    assign win_valid_o = r_win_valid;
    assign win_row_o   = r_win_row;
    assign win_col_o   = r_win_col;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_active     = 1'b0;
        pix_ready_o  = 1'b0;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                w_active = 1'b1;
                if (w_accept && w_col_last && (r_row == c_ROW_ONE)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_active = 1'b1;
                if (w_accept && w_col_last && (r_row == c_ROW_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                frame_done_o = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        busy_o      = w_active;
        pix_ready_o = w_active & w_down_ready;
    end

    // Position of the next pixel; cleared when a frame starts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if ((r_state == S_IDLE) && start_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : (r_row + c_ROW_ONE);
            end else begin
                r_col <= r_col + c_COL_ONE;
            end
        end
    end

    // Registered window flag and centre, aligned with the buffer's update edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else begin
`ifdef SOBEL_CTRL_BACKPRESSURE_EN
            // A flagged window stays presented until downstream takes it
            if (!(r_win_valid && !win_ready_i)) begin
                r_win_valid <= w_win_fire;
            end
`else
            r_win_valid <= w_win_fire;
`endif
            if (w_win_fire) begin
                r_win_row <= r_row - c_ROW_ONE;
                r_win_col <= r_col - c_COL_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_stream_ctrl
//  Description : Self-checking bench for sobel_stream_ctrl. A frame-level
//                reference model (pixel count, row = k / W, col = k % W)
//                predicts handshake, window and frame status every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_stream_ctrl;

    localparam int W    = 6;
    localparam int H    = 5;
    localparam int NWIN = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       pix_valid_i;
    logic [7:0] pix_data_i;
    logic       win_ready;
    logic       pix_ready_o;
    logic       buf_en_o;
    logic [7:0] buf_data_o;
    logic       win_valid_o;
    logic [2:0] win_row_o;
    logic [2:0] win_col_o;
    logic       busy_o;
    logic       frame_done_o;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 idle, 1 taking pixels, 2 done
    int m_phase = 0;
    int m_cnt   = 0;
    int m_wv    = 0;
    int m_wr    = 0;
    int m_wc    = 0;

    // Observed windows of the current frame
    int win_cnt, first_r, first_c, last_r, last_c;

    sobel_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SOBEL_CTRL_BACKPRESSURE_EN
        .win_ready_i  (win_ready),
`endif
        .start_i      (start_i),
        .pix_valid_i  (pix_valid_i),
        .pix_data_i   (pix_data_i),
        .pix_ready_o  (pix_ready_o),
        .buf_en_o     (buf_en_o),
        .buf_data_o   (buf_data_o),
        .win_valid_o  (win_valid_o),
        .win_row_o    (win_row_o),
        .win_col_o    (win_col_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model across the edge, then check registered outputs.
    task automatic step(input logic r, input logic st, input logic v,
                        input logic [7:0] d, input logic wr, output logic acc);
        logic wr_eff;
        logic exp_ready;
        int   rr, cc;
        @(negedge clk);
        rst = r; start_i = st; pix_valid_i = v; pix_data_i = d; win_ready = wr;
`ifdef SOBEL_CTRL_BACKPRESSURE_EN
        wr_eff = wr;
`else
        wr_eff = 1'b1;
`endif
        #1;
        exp_ready = (m_phase == 1) && wr_eff;
        chk("pix_ready", pix_ready_o, exp_ready);
        chk("buf_en", buf_en_o, v & exp_ready);
        chk("buf_data", buf_data_o, d);
        acc = v & exp_ready;
        if (win_valid_o === 1'b1 && wr_eff) begin
            if (win_cnt == 0) begin first_r = win_row_o; first_c = win_col_o; end
            last_r = win_row_o; last_c = win_col_o;
            win_cnt++;
        end
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_cnt = 0; m_wv = 0; m_wr = 0; m_wc = 0;
        end else begin
            if (!(m_wv != 0 && !wr_eff)) m_wv = 0;
            case (m_phase)
                0: if (st) begin m_phase = 1; m_cnt = 0; end
                1: if (acc) begin
                    rr = m_cnt / W;
                    cc = m_cnt % W;
                    if (rr >= 2 && cc >= 2) begin
                        m_wv = 1; m_wr = rr - 1; m_wc = cc - 1;
                    end
                    m_cnt++;
                    if (m_cnt == W * H) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        chk("win_valid", win_valid_o, m_wv);
        chk("busy", busy_o, m_phase == 1);
        chk("frame_done", frame_done_o, m_phase == 2);
        if (r || m_wv != 0) begin
            chk("win_row", win_row_o, m_wr);
            chk("win_col", win_col_o, m_wc);
        end
    endtask

    // mode 0: continuous, 1: every other cycle, 2: random gaps/data,
    // 3: continuous with a 3-cycle downstream stall at centre (1,2)
    task automatic run_frame(input int mode, input int npix);
        int   p, cyc, bp_left;
        bit   bp_done;
        logic v, wr, acc;
        logic [7:0] d;
        win_cnt = 0; p = 0; cyc = 0; bp_left = 0; bp_done = 0;
        step(0, 1, 0, 8'h00, 1, acc);
        while (p < npix && cyc < 400) begin
            case (mode)
                1:       v = cyc[0];
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            d  = (mode == 2) ? 8'($urandom) : 8'(p + 1);
            wr = 1'b1;
            if (mode == 3) begin
                if (!bp_done && win_valid_o === 1'b1 && win_row_o == 3'd1 && win_col_o == 3'd2) begin
                    bp_left = 3; bp_done = 1;
                end
                if (bp_left > 0) begin wr = 1'b0; bp_left--; end
            end
            step(0, 0, v, d, wr, acc);
            if (acc) p++;
            cyc++;
        end
        chk("pixels_accepted", p, npix);
        if (npix == W * H) begin
            // Pixels presented after the last one must be refused
            for (int i = 0; i < 6; i++) step(0, 0, 1, 8'(31 + i), 1, acc);
            chk("win_count", win_cnt, NWIN);
            chk("first_row", first_r, 1);
            chk("first_col", first_c, 1);
            chk("last_row", last_r, 3);
            chk("last_col", last_c, 4);
            if (mode == 3) chk("bp_applied", bp_done, 1);
        end
    endtask

    initial begin
        logic acc;
        rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = 8'h00; win_ready = 1'b1;
        win_cnt = 0; first_r = 0; first_c = 0; last_r = 0; last_c = 0;
        step(1, 0, 0, 8'h00, 1, acc);
        step(1, 0, 0, 8'h00, 1, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h55, 1, acc);
        run_frame(0, W * H);
        run_frame(1, W * H);
        run_frame(2, W * H);
        run_frame(0, 17);
        step(1, 0, 1, 8'hAA, 1, acc);
        step(0, 0, 1, 8'hAB, 1, acc);
        run_frame(0, W * H);
`ifdef SOBEL_CTRL_BACKPRESSURE_EN
        run_frame(3, W * H);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
